// File: rtl/pio_prog_loader.sv
// pio_prog_loader: boots the PIO block over its register port (CTRL off, INSTR_MEM fill, SM0 config, SM0 enable+restart).
// Latency: first select 2 cycles after start; each transaction takes >=1 cycle plus 1 idle cycle; N+5 writes per load.
// Backpressure: sel/RW/addr/wdata held while busy, abort with error after BUSY_TIMEOUT busy cycles; fetch waits on instr_valid.
// Build option: define PIO_LOADER_VERIFY_EN to read back every instruction word and abort on a mismatch.
module pio_prog_loader #(
    parameter logic [11:0] CTRL_ADDR      = 12'h000,
    parameter logic [11:0] INSTR_BASE     = 12'h048,
    parameter logic [11:0] CLKDIV_ADDR    = 12'h0C8,
    parameter logic [11:0] EXECCTRL_ADDR  = 12'h0CC,
    parameter logic [11:0] SHIFTCTRL_ADDR = 12'h0D0,
    parameter int          BUSY_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  prog_len,
    input  logic [31:0] clkdiv_val,
    input  logic [31:0] execctrl_val,
    input  logic [31:0] shiftctrl_val,
    output logic        instr_req,
    output logic [4:0]  instr_idx,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic        sel,
    output logic        RW,
    output logic [11:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        busy,
    output logic        loader_busy,
    output logic        done,
    output logic        error
);

    localparam int               CNT_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, DIS, FETCH, WR_INSTR, RD_INSTR, WR_CLKDIV, WR_EXEC, WR_SHIFT, EN, DONE
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [5:0]       n_words;
    logic [5:0]       word_idx;
    logic [31:0]      clkdiv_q;
    logic [31:0]      execctrl_q;
    logic [31:0]      shiftctrl_q;
    logic [CNT_W-1:0] busy_cnt;
    logic [11:0]      instr_addr;
    logic [11:0]      tx_addr;
    logic [31:0]      tx_wdata;
    logic             tx_rw;
    logic             last_word;
`ifdef PIO_LOADER_VERIFY_EN
    logic [15:0]      instr_word;
    // Only the low half of the readback is compared.
    logic             unused_rdata;
    assign unused_rdata = &{1'b0, rdata[31:16]};
`else
    // Without readback the slave's read data is never consulted.
    logic             unused_rdata;
    assign unused_rdata = &{1'b0, rdata};
`endif

    assign instr_idx  = word_idx[4:0];
    assign instr_addr = INSTR_BASE + {5'd0, word_idx[4:0], 2'b00};
    // word_idx never exceeds 31, so the +1 fits the 6-bit count of up to 32 words.
    assign last_word  = (word_idx + 6'd1) == n_words;

    // Per-state bus transaction contents and the step that follows its completion.
    always_comb begin
        nxt_state = IDLE;
        tx_addr   = CTRL_ADDR;
        tx_wdata  = 32'h0;
        tx_rw     = 1'b1;
        case (state)
            DIS: begin
                nxt_state = (n_words == 6'd0) ? WR_CLKDIV : FETCH;
            end
            WR_INSTR: begin
                tx_addr = instr_addr;
`ifdef PIO_LOADER_VERIFY_EN
                nxt_state = RD_INSTR;
`else
                nxt_state = last_word ? WR_CLKDIV : FETCH;
`endif
            end
            RD_INSTR: begin
                tx_addr   = instr_addr;
                tx_rw     = 1'b0;
                nxt_state = last_word ? WR_CLKDIV : FETCH;
            end
            WR_CLKDIV: begin
                tx_addr   = CLKDIV_ADDR;
                tx_wdata  = clkdiv_q;
                nxt_state = WR_EXEC;
            end
            WR_EXEC: begin
                tx_addr   = EXECCTRL_ADDR;
                tx_wdata  = execctrl_q;
                nxt_state = WR_SHIFT;
            end
            WR_SHIFT: begin
                tx_addr   = SHIFTCTRL_ADDR;
                tx_wdata  = shiftctrl_q;
                nxt_state = EN;
            end
            EN: begin
                tx_wdata  = 32'h0000_0011;
                nxt_state = DONE;
            end
            default: ;
        endcase
    end

    // Load sequencer: one bus transaction per state, one idle select cycle between transactions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            n_words     <= 6'd0;
            word_idx    <= 6'd0;
            clkdiv_q    <= 32'h0;
            execctrl_q  <= 32'h0;
            shiftctrl_q <= 32'h0;
            busy_cnt    <= '0;
            instr_req   <= 1'b0;
            sel         <= 1'b0;
            RW          <= 1'b0;
            addr        <= 12'h0;
            wdata       <= 32'h0;
            loader_busy <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef PIO_LOADER_VERIFY_EN
            instr_word  <= 16'h0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_words     <= (prog_len > 6'd32) ? 6'd32 : prog_len;
                        clkdiv_q    <= clkdiv_val;
                        execctrl_q  <= execctrl_val;
                        shiftctrl_q <= shiftctrl_val;
                        word_idx    <= 6'd0;
                        error       <= 1'b0;
                        loader_busy <= 1'b1;
                        state       <= DIS;
                    end
                end
                FETCH: begin
                    // The instruction write launches straight from the fetch edge,
                    // keeping the idle select gap at one cycle when data is ready.
                    if (instr_req && instr_valid) begin
                        instr_req <= 1'b0;
                        sel       <= 1'b1;
                        RW        <= 1'b1;
                        addr      <= instr_addr;
                        wdata     <= {16'h0, instr_data};
                        busy_cnt  <= '0;
                        state     <= WR_INSTR;
`ifdef PIO_LOADER_VERIFY_EN
                        instr_word <= instr_data;
`endif
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    loader_busy <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    if (!sel) begin
                        sel      <= 1'b1;
                        RW       <= tx_rw;
                        addr     <= tx_addr;
                        wdata    <= tx_wdata;
                        busy_cnt <= '0;
                    end else if (!busy) begin
                        sel   <= 1'b0;
                        state <= nxt_state;
                        if (nxt_state == FETCH) begin
                            instr_req <= 1'b1;
                            if (state != DIS) begin
                                word_idx <= word_idx + 6'd1;
                            end
                        end
`ifdef PIO_LOADER_VERIFY_EN
                        if (state == RD_INSTR && rdata[15:0] != instr_word) begin
                            instr_req   <= 1'b0;
                            error       <= 1'b1;
                            loader_busy <= 1'b0;
                            state       <= IDLE;
                        end
`endif
                    end else if (busy_cnt == CNT_LAST) begin
                        sel         <= 1'b0;
                        error       <= 1'b1;
                        loader_busy <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_prog_loader.sv
// tb_pio_prog_loader: drives pio_prog_loader against a register-slave and instruction-source model.
// Latency: expected bus traffic comes from a per-load transaction list built from the load parameters.
// Backpressure: the slave model can stall, randomly stall or hang busy; the source can delay instr_valid.
`timescale 1ns/1ps
module tb_pio_prog_loader;

    localparam logic [11:0] CTRL_A   = 12'h000;
    localparam logic [11:0] INSTR_A  = 12'h048;
    localparam logic [11:0] CLKDIV_A = 12'h0C8;
    localparam logic [11:0] EXEC_A   = 12'h0CC;
    localparam logic [11:0] SHIFT_A  = 12'h0D0;
    localparam int          LIMIT    = 5000;
`ifdef PIO_LOADER_VERIFY_EN
    localparam bit          VERIFY   = 1'b1;
`else
    localparam bit          VERIFY   = 1'b0;
`endif

    typedef struct packed {
        logic        rw;
        logic [11:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  prog_len = 6'd0;
    logic [31:0] clkdiv_val = 32'h0;
    logic [31:0] execctrl_val = 32'h0;
    logic [31:0] shiftctrl_val = 32'h0;
    logic        instr_req;
    logic [4:0]  instr_idx;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_data = 16'h0;
    logic        sel;
    logic        RW;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'h0;
    logic        busy = 1'b0;
    logic        loader_busy;
    logic        done;
    logic        error;

    int tests_run = 0;
    int tests_failed = 0;

    // Stimulus controls and observations shared with the slave model.
    logic [15:0] words [32];
    logic [15:0] imem [32];
    bit          stuck_busy = 1'b0;
    bit          busy_random = 1'b0;
    bit          stall_armed = 1'b0;
    logic [11:0] stall_addr = 12'h0;
    int          stall_left = 0;
    bit          valid_random = 1'b0;
    bit          corrupt_en = 1'b0;
    logic [11:0] corrupt_addr = 12'h0;
    txn_t        log_q[$];
    txn_t        exp_q[$];
    int          done_cnt, req_cycles, stall_seen, stall_unstable, busy_cycles, gap_bad, gap_cnt;
    logic [11:0] stall_addr_q;
    logic [31:0] stall_wdata_q;
    logic        prev_sel = 1'b0;

    pio_prog_loader dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
        .clkdiv_val(clkdiv_val), .execctrl_val(execctrl_val), .shiftctrl_val(shiftctrl_val),
        .instr_req(instr_req), .instr_idx(instr_idx), .instr_valid(instr_valid), .instr_data(instr_data),
        .sel(sel), .RW(RW), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
        .loader_busy(loader_busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Register slave and instruction source, evaluated mid-cycle for the next rising edge.
    always @(negedge clk) begin
        logic [11:0] off;
        off = addr - INSTR_A;
        instr_valid = valid_random ? ($urandom_range(0, 2) == 0) : 1'b1;
        instr_data  = words[instr_idx];
        if (instr_req) req_cycles++;
        if (done) done_cnt++;
        if (stuck_busy) begin
            busy = 1'b1;
        end else if (sel && stall_armed && addr == stall_addr) begin
            if (stall_left > 0) begin
                busy = 1'b1;
                if (stall_seen == 0) begin
                    stall_addr_q  = addr;
                    stall_wdata_q = wdata;
                end else if (addr !== stall_addr_q || wdata !== stall_wdata_q) begin
                    stall_unstable++;
                end
                stall_seen++;
                stall_left--;
            end else begin
                busy = 1'b0;
                stall_armed = 1'b0;
                if (addr !== stall_addr_q || wdata !== stall_wdata_q) stall_unstable++;
            end
        end else if (busy_random) begin
            busy = sel && ($urandom_range(0, 3) == 0);
        end else begin
            busy = 1'b0;
        end
        if (sel && busy) busy_cycles++;
        rdata = 32'h0;
        if (sel && !RW) begin
            rdata = {16'h0, imem[off[6:2]]};
            if (corrupt_en && addr == corrupt_addr) rdata = rdata ^ 32'h1;
        end
        if (sel && !busy) begin
            log_q.push_back(txn_t'({RW, addr, RW ? wdata : 32'h0}));
            if (RW && addr >= INSTR_A && addr < INSTR_A + 12'd128) imem[off[6:2]] = wdata[15:0];
        end
        if (sel) begin
            if (!prev_sel && gap_cnt >= 0 && gap_cnt != 1) gap_bad++;
            gap_cnt = 0;
        end else if (gap_cnt >= 0) begin
            gap_cnt++;
        end
        prev_sel = sel;
    end

    // Reference: the bus traffic one load should produce, from the load parameters alone.
    function automatic void build_expected(input int len, input int corrupt_idx);
        int n = (len > 32) ? 32 : len;
        exp_q.delete();
        exp_q.push_back(txn_t'({1'b1, CTRL_A, 32'h0}));
        for (int i = 0; i < n; i++) begin
            logic [11:0] a = INSTR_A + 12'(4 * i);
            exp_q.push_back(txn_t'({1'b1, a, {16'h0, words[i]}}));
            if (VERIFY) begin
                exp_q.push_back(txn_t'({1'b0, a, 32'h0}));
                if (i == corrupt_idx) return;
            end
        end
        exp_q.push_back(txn_t'({1'b1, CLKDIV_A, clkdiv_val}));
        exp_q.push_back(txn_t'({1'b1, EXEC_A, execctrl_val}));
        exp_q.push_back(txn_t'({1'b1, SHIFT_A, shiftctrl_val}));
        exp_q.push_back(txn_t'({1'b1, CTRL_A, 32'h0000_0011}));
    endfunction

    // Index of the first difference between observed and expected traffic, -1 when identical.
    function automatic int txn_diff();
        int m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (log_q[i] !== exp_q[i]) return i;
        return (log_q.size() != exp_q.size()) ? m : -1;
    endfunction

    function automatic txn_t at(input txn_t q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : txn_t'(0);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_obs();
        log_q.delete();
        done_cnt = 0; req_cycles = 0; stall_seen = 0; stall_unstable = 0;
        busy_cycles = 0; gap_bad = 0; gap_cnt = -1;
    endtask

    task automatic randomize_load();
        clkdiv_val    = $urandom();
        execctrl_val  = $urandom();
        shiftctrl_val = $urandom();
        for (int i = 0; i < 32; i++) words[i] = 16'($urandom());
    endtask

    task automatic start_load(input logic [5:0] len);
        prog_len = len;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit finished);
        int c = 0;
        while (loader_busy && c < LIMIT) begin
            tick(1);
            c++;
        end
        finished = !loader_busy;
        tick(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        tests_run++;
        if ({sel, RW, instr_req, loader_busy, done, error} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got sel/RW/req/lbusy/done/err=%b required 000000",
                     {sel, RW, instr_req, loader_busy, done, error});
        end
        tests_run++;
        if (addr !== 12'h0 || wdata !== 32'h0 || instr_idx !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got addr=%h wdata=%h idx=%0d required 0/0/0", addr, wdata, instr_idx);
        end
        reset = 1'b0;
        tick(3);
        tests_run++;
        if (sel !== 1'b0 || loader_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_start: got sel=%b lbusy=%b required 0/0", sel, loader_busy);
        end
    endtask

    task automatic test_basic();
        bit fin;
        int d;
        clear_obs();
        randomize_load();
        valid_random = 1'b0;
        words[0] = 16'hE081; words[1] = 16'h6001; words[2] = 16'h0001;
        build_expected(3, -1);
        start_load(6'd3);
        wait_idle(fin);
        tests_run++;
        if (!fin) begin tests_failed++; $display("FAIL basic_finish: loader_busy still high after %0d cycles", LIMIT); end
        tests_run++;
        if (log_q.size() !== (VERIFY ? 11 : 8)) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d transactions required %0d", log_q.size(), VERIFY ? 11 : 8);
        end
        d = txn_diff();
        tests_run++;
        if (d != -1) begin
            tests_failed++;
            $display("FAIL basic_txns: at %0d got %h required %h", d, at(log_q, d), at(exp_q, d));
        end
        tests_run++;
        if (done_cnt !== 1 || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done: got done pulses=%0d error=%b required 1/0", done_cnt, error);
        end
        tests_run++;
        if (gap_bad !== 0) begin
            tests_failed++;
            $display("FAIL basic_sel_gap: got %0d idle gaps not one cycle long required 0", gap_bad);
        end
    endtask

    task automatic test_busy_stall();
        bit fin;
        int d;
        clear_obs();
        randomize_load();
        stall_addr = CLKDIV_A; stall_left = 5; stall_armed = 1'b1;
        build_expected(3, -1);
        start_load(6'd3);
        wait_idle(fin);
        stall_armed = 1'b0;
        tests_run++;
        if (!fin || stall_seen !== 5) begin
            tests_failed++;
            $display("FAIL stall_cycles: got finished=%b busy cycles=%0d required 1/5", fin, stall_seen);
        end
        tests_run++;
        if (stall_unstable !== 0) begin
            tests_failed++;
            $display("FAIL stall_stable: got %0d addr/wdata changes under busy required 0", stall_unstable);
        end
        d = txn_diff();
        tests_run++;
        if (d != -1 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL stall_txns: at %0d got %h required %h, done=%0d required 1", d, at(log_q, d), at(exp_q, d), done_cnt);
        end
    endtask

    task automatic test_timeout();
        bit fin;
        int d;
        clear_obs();
        randomize_load();
        stuck_busy = 1'b1;
        start_load(6'd2);
        wait_idle(fin);
        stuck_busy = 1'b0;
        tests_run++;
        if (!fin || error !== 1'b1 || sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_error: got finished=%b error=%b sel=%b required 1/1/0", fin, error, sel);
        end
        tests_run++;
        if (busy_cycles !== 255) begin
            tests_failed++;
            $display("FAIL timeout_len: got %0d busy cycles before abort required 255", busy_cycles);
        end
        tests_run++;
        if (done_cnt !== 0 || log_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL timeout_nodone: got done=%0d completed=%0d required 0/0", done_cnt, log_q.size());
        end
        clear_obs();
        randomize_load();
        build_expected(2, -1);
        start_load(6'd2);
        tests_run++;
        if (error !== 1'b0 || loader_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_clear: got error=%b lbusy=%b after start required 0/1", error, loader_busy);
        end
        wait_idle(fin);
        d = txn_diff();
        tests_run++;
        if (!fin || d != -1 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL timeout_recover: at %0d got %h required %h, done=%0d required 1", d, at(log_q, d), at(exp_q, d), done_cnt);
        end
    endtask

    task automatic test_len_zero();
        bit fin;
        int d;
        clear_obs();
        randomize_load();
        build_expected(0, -1);
        start_load(6'd0);
        wait_idle(fin);
        tests_run++;
        if (!fin || log_q.size() !== 5 || req_cycles !== 0) begin
            tests_failed++;
            $display("FAIL len0_count: got finished=%b txns=%0d req cycles=%0d required 1/5/0", fin, log_q.size(), req_cycles);
        end
        d = txn_diff();
        tests_run++;
        if (d != -1 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL len0_txns: at %0d got %h required %h, done=%0d required 1", d, at(log_q, d), at(exp_q, d), done_cnt);
        end
    endtask

    task automatic test_len_clamp();
        bit fin;
        int d;
        int n_instr = 0;
        logic [11:0] last_a = 12'h0;
        clear_obs();
        randomize_load();
        valid_random = 1'b1;
        build_expected(40, -1);
        start_load(6'd40);
        wait_idle(fin);
        valid_random = 1'b0;
        foreach (log_q[i]) begin
            if (log_q[i].rw && log_q[i].addr >= INSTR_A && log_q[i].addr < CLKDIV_A) begin
                n_instr++;
                last_a = log_q[i].addr;
            end
        end
        tests_run++;
        if (!fin || n_instr !== 32 || last_a !== 12'h0C4) begin
            tests_failed++;
            $display("FAIL clamp_instr: got finished=%b writes=%0d last=%h required 1/32/0c4", fin, n_instr, last_a);
        end
        d = txn_diff();
        tests_run++;
        if (d != -1 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL clamp_txns: at %0d got %h required %h, done=%0d required 1", d, at(log_q, d), at(exp_q, d), done_cnt);
        end
    endtask

    task automatic test_mid_reset();
        bit fin;
        int d;
        int c = 0;
        clear_obs();
        randomize_load();
        valid_random = 1'b1;
        start_load(6'd5);
        while (!(instr_req && instr_idx == 5'd2) && c < LIMIT) begin
            tick(1);
            c++;
        end
        tests_run++;
        if (c >= LIMIT) begin
            tests_failed++;
            $display("FAIL midreset_reach: fetch of word 2 not seen within %0d cycles", LIMIT);
        end
        reset = 1'b1;
        tick(1);
        tests_run++;
        if ({sel, RW, instr_req, loader_busy, done, error} !== 6'b0 || addr !== 12'h0 || wdata !== 32'h0 || instr_idx !== 5'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got ctrl=%b addr=%h wdata=%h idx=%0d required all 0",
                     {sel, RW, instr_req, loader_busy, done, error}, addr, wdata, instr_idx);
        end
        reset = 1'b0;
        valid_random = 1'b0;
        tick(1);
        clear_obs();
        randomize_load();
        build_expected(2, -1);
        start_load(6'd2);
        wait_idle(fin);
        d = txn_diff();
        tests_run++;
        if (!fin || d != -1 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL midreset_restart: at %0d got %h required %h, done=%0d required 1", d, at(log_q, d), at(exp_q, d), done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        bit fin;
        int d;
        clear_obs();
        randomize_load();
        valid_random = 1'b1;
        build_expected(4, -1);
        start_load(6'd4);
        for (int k = 0; k < 3; k++) begin
            tick($urandom_range(1, 4));
            if (loader_busy) begin
                prog_len = 6'd0;
                clkdiv_val = ~clkdiv_val;
                start = 1'b1;
                tick(1);
                start = 1'b0;
            end
        end
        wait_idle(fin);
        valid_random = 1'b0;
        d = txn_diff();
        tests_run++;
        if (!fin || d != -1) begin
            tests_failed++;
            $display("FAIL ignore_txns: at %0d got %h required %h", d, at(log_q, d), at(exp_q, d));
        end
        tests_run++;
        if (done_cnt !== 1 || loader_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_done: got done=%0d lbusy=%b required 1/0", done_cnt, loader_busy);
        end
    endtask

    task automatic test_verify_corrupt();
        bit fin;
        int d;
        clear_obs();
        randomize_load();
        corrupt_en = 1'b1;
        corrupt_addr = INSTR_A + 12'd4;
        build_expected(4, 1);
        start_load(6'd4);
        wait_idle(fin);
        corrupt_en = 1'b0;
        d = txn_diff();
        tests_run++;
        if (!fin || d != -1) begin
            tests_failed++;
            $display("FAIL corrupt_txns: at %0d got %h required %h", d, at(log_q, d), at(exp_q, d));
        end
        tests_run++;
        if (error !== VERIFY || done_cnt !== (VERIFY ? 0 : 1)) begin
            tests_failed++;
            $display("FAIL corrupt_status: got error=%b done=%0d required %b/%0d", error, done_cnt, VERIFY, VERIFY ? 0 : 1);
        end
    endtask

    task automatic test_random();
        bit fin;
        int d;
        int len;
        for (int it = 0; it < 6; it++) begin
            clear_obs();
            randomize_load();
            valid_random = 1'b1;
            busy_random = 1'b1;
            len = $urandom_range(0, 40);
            build_expected(len, -1);
            start_load(6'(len));
            wait_idle(fin);
            d = txn_diff();
            tests_run++;
            if (!fin || d != -1 || done_cnt !== 1 || error !== 1'b0) begin
                tests_failed++;
                $display("FAIL random_%0d len=%0d: at %0d got %h required %h, done=%0d error=%b required 1/0",
                         it, len, d, at(log_q, d), at(exp_q, d), done_cnt, error);
            end
        end
        valid_random = 1'b0;
        busy_random = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            words[i] = 16'h0;
            imem[i] = 16'h0;
        end
        clear_obs();
        test_reset();
        test_basic();
        test_busy_stall();
        test_timeout();
        test_len_zero();
        test_len_clamp();
        test_mid_reset();
        test_start_ignored();
        test_verify_corrupt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pio_prog_loader.md
Name: pio_prog_loader

Overview:
- Register-bus initiator that drives the PIO block's register slave port (sel/RW/addr/wdata/rdata/busy).
- On `start` it:
  - disables the state machines;
  - fetches N 16-bit instruction words from an upstream source and writes them into INSTR_MEM;
  - programs SM0 CLKDIV, EXECCTRL and SHIFTCTRL;
  - enables and restarts SM0.
- Sits between boot/host logic and the PIO top, replacing testbench-driven register writes.

Parameters:
- CTRL_ADDR, 12'h000, byte address of CTRL.
- INSTR_BASE, 12'h048, byte address of INSTR_MEM0; word i is at INSTR_BASE + 4*i.
- CLKDIV_ADDR, 12'h0C8, SM0_CLKDIV address.
- EXECCTRL_ADDR, 12'h0CC, SM0_EXECCTRL address.
- SHIFTCTRL_ADDR, 12'h0D0, SM0_SHIFTCTRL address.
- BUSY_TIMEOUT, 255, maximum consecutive busy cycles tolerated per transaction.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load
- prog_len  in  6  number of instruction words; sampled on start
- clkdiv_val  in  32  CLKDIV value; sampled on start
- execctrl_val  in  32  EXECCTRL value; sampled on start
- shiftctrl_val  in  32  SHIFTCTRL value; sampled on start
- instr_req  out  1  request for instruction word instr_idx
- instr_idx  out  5  index of the requested word
- instr_valid  in  1  instr_data valid
- instr_data  in  16  instruction word
- sel  out  1  bus select
- RW  out  1  1 = write, 0 = read
- addr  out  12  bus address
- wdata  out  32  write data
- rdata  in  32  read data
- busy  in  1  slave stall
- loader_busy  out  1  high from the cycle after an accepted start until done/error
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky fault; cleared by the next accepted start or by reset

Behaviour:
- Clocking: single clock `clk`; `reset` is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE. Reset mid-operation drops `sel` at the same edge; no partial transaction is completed.
- Bus transaction:
  - Loader registers `sel=1` with RW/addr/wdata.
  - These are held stable while `busy=1`.
  - The transaction completes on the first edge with `sel && !busy`; read data is sampled at that edge.
  - `sel` is low for exactly one cycle between transactions.
- Fetch handshake:
  - `instr_req` is held high, with `instr_idx` stable, until an edge with `instr_valid=1`.
  - `instr_data` is captured at that edge.
  - `instr_req` is low in the following cycle.
- FSM: IDLE -> DIS -> (FETCH -> WR_INSTR) x N -> WR_CLKDIV -> WR_EXEC -> WR_SHIFT -> EN -> DONE -> IDLE.
  - DIS: writes 32'h0 to CTRL_ADDR.
  - WR_INSTR: writes {16'h0, instr_data} to INSTR_BASE + {idx, 2'b00}.
  - EN: writes 32'h0000_0011 to CTRL_ADDR (SM0 enable, bit 0; SM0 restart, bit 4).
  - DONE: pulses `done` for one cycle.
- prog_len rules:
  - N = prog_len, clamped to 32 if prog_len > 32.
  - N = 0 skips FETCH/WR_INSTR entirely.
- Write count per load: exactly N + 5 writes.
- start handling: `start` is ignored when not in IDLE. An accepted start clears `error`.
- Timeout:
  - A per-transaction busy counter resets at each new transaction.
  - If `busy` is seen high for BUSY_TIMEOUT consecutive cycles: drop `sel`, set `error`, return to IDLE with no `done` pulse and no EN write.
- instr_valid is never timed out; FETCH waits indefinitely.
- `instr_valid` while `instr_req=0` is ignored.

Optional Feature:
- Macro: PIO_LOADER_VERIFY_EN.
- Enabled:
  - Each WR_INSTR is followed by a RD_INSTR read of the same address.
  - If rdata[15:0] differs from the written word: set `error`, skip the remaining steps (no CLKDIV/EXEC/SHIFT/EN writes), return to IDLE with no `done`.
  - Transaction count on success is 2N + 5.
- Disabled:
  - No reads are ever issued; RW is always 1 whenever sel=1.
  - `error` is set only by timeout.

Test Plan:
- Basic load, busy=0, instr_valid tied 1, prog_len=3, words 16'hE081 / 16'h6001 / 16'h0001 -> 8 writes, in order:
  - CTRL=0;
  - 0x048=0000E081, 0x04C=00006001, 0x050=00000001;
  - CLKDIV, EXECCTRL, SHIFTCTRL with the sampled values;
  - CTRL=00000011;
  - then one `done` pulse and `error`=0.
- Busy stall: busy held high for 5 cycles during the CLKDIV write -> addr/wdata stable throughout, transaction completes on the 6th cycle, sequence otherwise identical.
- Timeout: busy stuck high on the first write -> `error`=1 after 255 busy cycles, `sel`=0, no `done`; a second `start` then clears `error`.
- Boundaries:
  - prog_len=0 -> exactly 5 writes, no `instr_req`;
  - prog_len=40 -> 32 INSTR writes, the last at 0x0C4.
- Mid-operation events:
  - reset asserted during FETCH of word 2 -> next cycle all outputs 0 and FSM in IDLE;
  - `start` pulsed while `loader_busy`=1 -> ignored.
- With PIO_LOADER_VERIFY_EN: slave returns a corrupted rdata for word 1 -> `error`=1, no CLKDIV/EN writes, no `done`. Matching rdata -> 2N+5 transactions and `done`.
